// File: rtl/radio_pkg.sv
// Shared constants and types for the radio_dummy PRBS-15 radio stand-in.
package radio_pkg;

    localparam int unsigned LFSR_W = 15;
    localparam int unsigned TAP_A  = 14;
    localparam int unsigned TAP_B  = 13;

    typedef logic [LFSR_W-1:0] lfsr_t;

    localparam lfsr_t SEED_I_DEF = 15'h0001;
    localparam lfsr_t SEED_Q_DEF = 15'h0100;
    localparam lfsr_t SEED_SAFE  = 15'h0001;

    // An all-zero LFSR would lock up, so a zero seed is swapped for a safe one.
    function automatic lfsr_t seed_guard(input lfsr_t seed);
        return (seed == '0) ? SEED_SAFE : seed;
    endfunction

endpackage

// File: rtl/prbs15_gen.sv
// PRBS-15 (x^15+x^14+1, Fibonacci) generator with registered output bit.
module prbs15_gen
    import radio_pkg::*;
(
    input  logic  clk16,
    input  logic  rst_n,
    input  logic  en,
    input  lfsr_t seed,
    input  logic  mix,
    output logic  bit_o
);

    lfsr_t lfsr_q, lfsr_d;
    logic  bit_q, bit_d;
    logic  fb_c;

    // Advance the LFSR and capture the freshly generated bit on enable.
    always_comb begin
        fb_c   = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
        lfsr_d = lfsr_q;
        bit_d  = bit_q;
        if (en) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb_c};
            bit_d  = fb_c ^ mix;
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= seed_guard(seed);
            bit_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            bit_q  <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/radio_dummy.sv
// Drop-in stand-in for the radio input block: free-running PRBS-15 I/Q samples.
// Define RADIO_DUMMY_MIX_EN to overlay synchronized i1/q1 onto the PRBS streams.
module radio_dummy
    import radio_pkg::*;
#(
    parameter int unsigned DIV    = 1,
    parameter lfsr_t       SEED_I = SEED_I_DEF,
    parameter lfsr_t       SEED_Q = SEED_Q_DEF
) (
    input  logic clk16,
    input  logic rst_n,
    input  logic i1,
    input  logic q1,
    output logic data_i,
    output logic data_q
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_c;
    logic             mix_i_c, mix_q_c;

    // Sample strobe divider: counts 0..DIV-1, strobing on the last count.
    always_comb begin
        strobe_c = (cnt_q == CNT_W'(DIV - 1));
        cnt_d    = strobe_c ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef RADIO_DUMMY_MIX_EN
    logic [1:0] i1_sync_q, q1_sync_q;

    // Raw radio sign bits are asynchronous to clk16; two-flop synchronize them.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            i1_sync_q <= 2'b00;
            q1_sync_q <= 2'b00;
        end else begin
            i1_sync_q <= {i1_sync_q[0], i1};
            q1_sync_q <= {q1_sync_q[0], q1};
        end
    end

    assign mix_i_c = i1_sync_q[1];
    assign mix_q_c = q1_sync_q[1];
`else
    logic unused_radio_in_c;

    assign unused_radio_in_c = i1 ^ q1;
    assign mix_i_c           = 1'b0;
    assign mix_q_c           = 1'b0;
`endif

    prbs15_gen u_prbs_i (
        .clk16 (clk16),
        .rst_n (rst_n),
        .en    (strobe_c),
        .seed  (SEED_I),
        .mix   (mix_i_c),
        .bit_o (data_i)
    );

    prbs15_gen u_prbs_q (
        .clk16 (clk16),
        .rst_n (rst_n),
        .en    (strobe_c),
        .seed  (SEED_Q),
        .mix   (mix_q_c),
        .bit_o (data_q)
    );

endmodule

// File: tb/tb_radio_dummy.sv
// Scoreboard bench for radio_dummy: DIV=1 and DIV=4 instances against a bit-recurrence model.
module tb_radio_dummy;

    localparam int NS = 70000;

    logic clk16 = 1'b0;
    logic rst_n = 1'b0;
    logic i1    = 1'bx;
    logic q1    = 1'bx;
    logic d1_i, d1_q, d4_i, d4_q;

    bit        seq_i[NS];
    bit        seq_q[NS];
    logic [3:0] exp_fifo[$];
    logic [3:0] mon_e;
    int        tests = 0;
    int        fails = 0;
    int        k     = 0;

    always #5 clk16 = ~clk16;

    radio_dummy #(.DIV(1)) u_div1 (
        .clk16  (clk16),
        .rst_n  (rst_n),
        .i1     (i1),
        .q1     (q1),
        .data_i (d1_i),
        .data_q (d1_q)
    );

    radio_dummy #(.DIV(4)) u_div4 (
        .clk16  (clk16),
        .rst_n  (rst_n),
        .i1     (i1),
        .q1     (q1),
        .data_i (d4_i),
        .data_q (d4_q)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s (k=%0d): got %b want %b", name, k, got, want);
        end
    endtask

    // Sample stream n is bit g[15+n] with g[m+15] = g[m] ^ g[m+1], seeded oldest bit first.
    task automatic gen(input logic [14:0] seed, input bit is_q);
        bit          g[$];
        logic [14:0] s;
        bit          b;
        s = (seed == 15'h0) ? 15'h0001 : seed;
        for (int j = 0; j < 15; j++) g.push_back(s[14-j]);
        for (int n = 0; n < NS; n++) begin
            b = g[n] ^ g[n+1];
            g.push_back(b);
            if (is_q) seq_q[n] = b;
            else      seq_i[n] = b;
        end
    endtask

    // Expected {div1 I, div1 Q, div4 I, div4 Q} after edge k since reset release.
    function automatic logic [3:0] expect_at(input int edge_k);
        logic [3:0] e;
        int         n4;
        e  = 4'b0000;
        n4 = edge_k / 4;
        if (edge_k >= 1) e[3:2] = {seq_i[edge_k-1], seq_q[edge_k-1]};
        if (n4 >= 1)     e[1:0] = {seq_i[n4-1], seq_q[n4-1]};
        return e;
    endfunction

    task automatic drive_random_inputs();
        case ($urandom_range(0, 2))
            0:       i1 = 1'b0;
            1:       i1 = 1'b1;
            default: i1 = 1'bx;
        endcase
        case ($urandom_range(0, 2))
            0:       q1 = 1'b0;
            1:       q1 = 1'b1;
            default: q1 = 1'bx;
        endcase
    endtask

    task automatic run(input int n);
        logic [15:0] pi;
        logic [7:0]  pq;
        pi = '0;
        pq = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk16);
            k++;
            exp_fifo.push_back(expect_at(k));
            #1;
            if (k <= 16) pi = {pi[14:0], d1_i};
            if (k <= 8)  pq = {pq[6:0], d1_q};
            drive_random_inputs();
        end
        if (n >= 16) begin
            check("first16_data_i", pi, 16'b0000000000000110);
            check("first8_data_q", {8'h00, pq}, {8'h00, 8'b00000110});
        end
    endtask

    // Monitor: pops one expected sample per cycle and compares on the falling edge.
    always @(negedge clk16) begin
        if (exp_fifo.size() != 0) begin
            mon_e = exp_fifo.pop_front();
            check("sample", {12'h000, d1_i, d1_q, d4_i, d4_q}, {12'h000, mon_e});
        end
    end

    initial begin
        gen(15'h0001, 1'b0);
        gen(15'h0100, 1'b1);

        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk16);
            exp_fifo.push_back(4'b0000);
        end
        #1 rst_n = 1'b1;
        k = 0;

        run(100 + int'($urandom_range(0, 20)));

        // Half-cycle reset pulse between edges; the next negedge sees it asserted.
        @(posedge clk16);
        k++;
        exp_fifo.push_back(4'b0000);
        #1 rst_n = 1'b0;
        #1 check("async_reset", {12'h000, d1_i, d1_q, d4_i, d4_q}, 16'h0000);
        #4 rst_n = 1'b1;
        k = 0;

        run(65600);

        repeat (2) @(negedge clk16);
        check("fifo_drained", 16'(exp_fifo.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/radio_dummy.md
Name: radio_dummy

Overview:
Stand-in for the MAX2769 radio front-end input block. It produces deterministic pseudo-random 1-bit I and Q sample streams from two PRBS-15 generators clocked by the 16 MHz sample clock. Downstream correlator and pipeline logic can be exercised without real RF data. Port shape matches the real radio input block, so the two are drop-in interchangeable.

Parameters:
DIV, 1, sample strobe divider; a new I/Q sample is produced every DIV clk16 cycles (legal range 1..256).
SEED_I, 15'h0001, initial I LFSR state; a value of 0 is replaced by 15'h0001.
SEED_Q, 15'h0100, initial Q LFSR state; a value of 0 is replaced by 15'h0001.

Ports:
clk16  input  1  sample clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
i1     input  1  raw I sign bit from radio; ignored unless optional feature is enabled.
q1     input  1  raw Q sign bit from radio; ignored unless optional feature is enabled.
data_i output 1  registered I sample bit.
data_q output 1  registered Q sample bit.

Behaviour:
- Clocking and reset: single clock clk16; reset is asynchronous, active-low, named rst_n.
- Reset values, while rst_n=0:
  - lfsr_i = SEED_I, lfsr_q = SEED_Q (zero seeds replaced by 15'h0001).
  - Divider counter = 0.
  - data_i = 0, data_q = 0.
- Strobe generation:
  - Counter runs 0..DIV-1 and wraps to 0.
  - strobe = (count == DIV-1).
  - With DIV=1, strobe is asserted every cycle, starting on the first rising edge after rst_n deasserts.
- PRBS-15 update, polynomial x^15+x^14+1, Fibonacci form, applied to each LFSR on strobe:
  - fb = s[14] ^ s[13].
  - s <= {s[13:0], fb}.
  - Output bit <= fb, i.e. data_i/data_q take the newly generated bit in the same edge.
- Timing:
  - Latency is 1 cycle from strobe to output.
  - Outputs hold their value between strobes.
- Sequence period is 32767 strobes. The LFSR never reaches the all-zero state.
- i1/q1 have no effect in the default build. Outputs must be 0/1 (never X) even when i1/q1 are X or undriven.
- Reset asserted mid-run:
  - Outputs go to 0 immediately (asynchronous).
  - After release, the sequence restarts from the seeds; the first sample is identical to the post-power-up first sample.
- No handshake; outputs are free-running.

Optional Feature:
RADIO_DUMMY_MIX_EN
- Defined:
  - i1 and q1 each pass through a 2-flop synchronizer, reset to 0.
  - On strobe: data_i <= fb_i ^ i1_sync and data_q <= fb_q ^ q1_sync. This overlays the real radio bits onto the PRBS.
  - Latency from i1 to data_i is 3 edges with DIV=1.
- Not defined: no synchronizers are instantiated and i1/q1 are unconnected internally.

Decomposition:
- Package radio_pkg:
  - LFSR_W = 15.
  - Tap indices TAP_A = 14 and TAP_B = 13.
  - Default seed constants.
  - Typedef lfsr_t as a 15-bit logic vector.
- Sub-module prbs15_gen, instantiated twice (I and Q):
  - Ports: clk16, rst_n, en, seed, bit_o.
  - Contains the LFSR, the zero-seed guard and the output register.
- The top level holds the divider counter and the optional synchronizers.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with i1/q1=X -> data_i=0 and data_q=0 throughout, no X on outputs.
- Default run: DIV=1, release reset, i1/q1=X -> data_i over the first 16 edges = 0000000000000110; data_q over the first 8 edges = 00000110.
- Period: run 32767×2 strobes -> the data_i sequence repeats exactly with period 32767; the LFSR state never equals 0.
- Divider: DIV=4 -> outputs change only on every 4th edge; the first new sample appears on the 4th edge after reset release; the held-value sequence equals the DIV=1 sequence.
- Reset mid-run: after 100 cycles, pulse rst_n low for half a cycle -> outputs go to 0 asynchronously; after release, data_i replays 0000000000000110.
- With RADIO_DUMMY_MIX_EN, DIV=1, i1 held at 1 -> after synchronizer fill, data_i equals the inverted default PRBS (e.g. 1111...001 pattern); with q1=0, data_q is unchanged from the default build.
